// File: rtl/gauss_raster_feeder_if.sv
// Stream-side bundle of the Gaussian raster feeder: upstream valid/ready input plus the
// line-buffer write port with position tags.
interface gauss_raster_feeder_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 128,
    parameter int unsigned IMG_HEIGHT = 128,
    parameter int unsigned PAD_ROWS   = 2
);
    localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW = (IMG_HEIGHT + PAD_ROWS > 1) ?
                                   $clog2(IMG_HEIGHT + PAD_ROWS) : 1;

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_ready;
    logic                  lb_valid;
    logic [DATA_WIDTH-1:0] lb_data;
    logic [ColW-1:0]       col;
    logic [RowW-1:0]       row;
    logic                  pad_active;

    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, lb_valid, lb_data, col, row, pad_active
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, lb_valid, lb_data, col, row, pad_active
    );
endinterface

// File: rtl/gauss_raster_feeder.sv
// Forwards one W x H frame in raster order through a one-entry output register with a skid
// entry behind it, then appends PAD_ROWS rows of zero pixels to flush the window pipeline.
module gauss_raster_feeder #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_WIDTH  = 128,
    parameter int unsigned IMG_HEIGHT = 128,
    parameter int unsigned PAD_ROWS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    gauss_raster_feeder_if.master bus
);
    localparam int unsigned ColW    = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned RowW    = (IMG_HEIGHT + PAD_ROWS > 1) ?
                                      $clog2(IMG_HEIGHT + PAD_ROWS) : 1;
    localparam int unsigned NumPix  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned NumPad  = PAD_ROWS * IMG_WIDTH;
    localparam int unsigned InCntW  = $clog2(NumPix + 1);
    localparam int unsigned PadCntW = (NumPad > 0) ? $clog2(NumPad + 1) : 1;

    localparam logic [InCntW-1:0]  InLast  = InCntW'(NumPix);
    localparam logic [PadCntW-1:0] PadLast = PadCntW'(NumPad);
    localparam logic [ColW-1:0]    ColLast = ColW'(IMG_WIDTH - 1);
    localparam logic [RowW-1:0]    RowLast = RowW'(IMG_HEIGHT + PAD_ROWS - 1);

    typedef enum logic [1:0] {StIdle, StStream, StFlush, StDrain} state_e;

    state_e                state_q, state_d;
    logic [InCntW-1:0]     in_cnt_q, in_cnt_d;
    logic [PadCntW-1:0]    pad_cnt_q, pad_cnt_d;
    logic                  or_full_q, or_full_d;
    logic [DATA_WIDTH-1:0] or_data_q, or_data_d;
    logic                  or_pad_q, or_pad_d;
    logic                  sk_full_q, sk_full_d;
    logic [DATA_WIDTH-1:0] sk_data_q, sk_data_d;
    logic [ColW-1:0]       col_q, col_d;
    logic [RowW-1:0]       row_q, row_d;
    logic                  s_ready_q, s_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic accept;
    logic drain;
    logic or_free;

    assign accept  = bus.s_valid && s_ready_q;
    assign drain   = or_full_q && bus.m_ready;
    assign or_free = !or_full_q || drain;

    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        pad_cnt_d = pad_cnt_q;
        or_full_d = or_full_q;
        or_data_d = or_data_q;
        or_pad_d  = or_pad_q;
        sk_full_d = sk_full_q;
        sk_data_d = sk_data_q;
        col_d     = col_q;
        row_d     = row_q;
        done_d    = 1'b0;

        // An emptied OR reads as zero so pad_active never lingers past the last pad.
        if (drain) begin
            or_full_d = 1'b0;
            or_data_d = '0;
            or_pad_d  = 1'b0;
        end

        // Skid entry has priority to keep raster order; s_ready is low while it is full.
        if (or_free) begin
            if (sk_full_q) begin
                or_full_d = 1'b1;
                or_data_d = sk_data_q;
                or_pad_d  = 1'b0;
                sk_full_d = 1'b0;
            end else if (accept) begin
                or_full_d = 1'b1;
                or_data_d = bus.s_data;
                or_pad_d  = 1'b0;
            end else if (state_q == StFlush && pad_cnt_q != PadLast) begin
                or_full_d = 1'b1;
                or_data_d = '0;
                or_pad_d  = 1'b1;
                pad_cnt_d = pad_cnt_q + PadCntW'(1);
            end
        end else if (accept) begin
            sk_full_d = 1'b1;
            sk_data_d = bus.s_data;
        end

        if (accept) begin
            in_cnt_d = in_cnt_q + InCntW'(1);
        end

        if (drain) begin
            if (col_q == ColLast) begin
                col_d = '0;
                row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end

        unique case (state_q)
            StIdle: begin
                // The done cycle is already idle; a start landing on it is dropped.
                if (start && !done_q) begin
                    state_d   = StStream;
                    in_cnt_d  = '0;
                    pad_cnt_d = '0;
                    col_d     = '0;
                    row_d     = '0;
                end
            end
            StStream: begin
                if (in_cnt_d == InLast && !sk_full_d) begin
                    state_d = (PAD_ROWS != 0) ? StFlush : StDrain;
                end
            end
            StFlush: begin
                if (pad_cnt_d == PadLast) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!or_full_d) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        s_ready_d = (state_d == StStream) && !sk_full_d && (in_cnt_d != InLast);
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            in_cnt_q  <= '0;
            pad_cnt_q <= '0;
            or_full_q <= 1'b0;
            or_data_q <= '0;
            or_pad_q  <= 1'b0;
            sk_full_q <= 1'b0;
            sk_data_q <= '0;
            col_q     <= '0;
            row_q     <= '0;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_cnt_q  <= in_cnt_d;
            pad_cnt_q <= pad_cnt_d;
            or_full_q <= or_full_d;
            or_data_q <= or_data_d;
            or_pad_q  <= or_pad_d;
            sk_full_q <= sk_full_d;
            sk_data_q <= sk_data_d;
            col_q     <= col_d;
            row_q     <= row_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.s_ready    = s_ready_q;
    assign bus.lb_valid   = drain;
    assign bus.lb_data    = or_data_q;
    assign bus.col        = col_q;
    assign bus.row        = row_q;
    assign bus.pad_active = or_pad_q;
    assign busy           = busy_q;
    assign done           = done_q;
endmodule

// File: tb/tb_gauss_raster_feeder.sv
// Scoreboard bench: each frame's expected raster (pixels, then zero pads, positions from the
// pixel index) is queued when the frame is issued; monitors pop on every lb_valid.
module tb_gauss_raster_feeder;
    localparam int DW = 8;
    localparam int WA = 4;
    localparam int HA = 3;
    localparam int PA = 2;
    localparam int NA = WA * HA;
    localparam int WB = 4;
    localparam int HB = 2;

    typedef struct {
        logic [DW-1:0] d;
        int            r;
        int            c;
        bit            pad;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start_a, busy_a, done_a;
    logic start_b, busy_b, done_b;

    gauss_raster_feeder_if #(.DATA_WIDTH(DW), .IMG_WIDTH(WA), .IMG_HEIGHT(HA),
                             .PAD_ROWS(PA)) ifa ();
    gauss_raster_feeder_if #(.DATA_WIDTH(DW), .IMG_WIDTH(WB), .IMG_HEIGHT(HB),
                             .PAD_ROWS(0)) ifb ();

    gauss_raster_feeder #(.DATA_WIDTH(DW), .IMG_WIDTH(WA), .IMG_HEIGHT(HA),
                          .PAD_ROWS(PA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .bus(ifa)
    );
    gauss_raster_feeder #(.DATA_WIDTH(DW), .IMG_WIDTH(WB), .IMG_HEIGHT(HB),
                          .PAD_ROWS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .bus(ifb)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;
    logic [DW-1:0] px_a [NA];
    logic [DW-1:0] px_b [WB*HB];

    int mode_a = 0;
    int ph_a = 0;
    int xfer_a, acc_a, run_a, max_run_a, low_a, max_low_a, done_cnt_a;
    int first_acc_a, first_xfer_a, last_xfer_a;
    int xfer_b, last_xfer_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        ifa.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode_a)
                0:       ifa.m_ready = 1'b1;
                1:       ifa.m_ready = (ph_a % 4 == 0) || (ph_a % 4 == 3);
                default: ifa.m_ready = ($urandom_range(0, 3) != 0);
            endcase
            ph_a++;
        end
    end

    // Monitor for the padded instance.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (ifa.lb_valid) begin
                check("a_no_valid_while_stalled", ifa.m_ready, 1);
                check("a_output_expected", exp_a.size() != 0, 1);
                if (exp_a.size() != 0) begin
                    ea = exp_a.pop_front();
                    check("a_data", ifa.lb_data, ea.d);
                    check("a_row", ifa.row, ea.r);
                    check("a_col", ifa.col, ea.c);
                    check("a_pad", ifa.pad_active, ea.pad);
                end
                if (xfer_a == 0) first_xfer_a = cyc;
                xfer_a++;
                last_xfer_a = cyc;
                run_a++;
                if (run_a > max_run_a) max_run_a = run_a;
            end else begin
                run_a = 0;
            end
            if (ifa.s_valid && ifa.s_ready) begin
                if (acc_a == 0) first_acc_a = cyc;
                acc_a++;
            end
            if (busy_a && acc_a < NA) begin
                low_a = ifa.s_ready ? 0 : low_a + 1;
                if (low_a > max_low_a) max_low_a = low_a;
            end
            if (!busy_a) check("a_s_ready_idle", ifa.s_ready, 0);
            if (done_a) begin
                check("a_done_timing", cyc - last_xfer_a, 1);
                check("a_done_busy_low", busy_a, 0);
                check("a_done_queue_empty", exp_a.size(), 0);
                done_cnt_a++;
            end
        end
    end

    // Monitor for the unpadded instance.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (ifb.lb_valid) begin
                check("b_output_expected", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) begin
                    eb = exp_b.pop_front();
                    check("b_data", ifb.lb_data, eb.d);
                    check("b_row", ifb.row, eb.r);
                    check("b_col", ifb.col, eb.c);
                    check("b_pad", ifb.pad_active, eb.pad);
                end
                xfer_b++;
                last_xfer_b = cyc;
            end
            if (done_b) begin
                check("b_done_timing", cyc - last_xfer_b, 1);
                check("b_done_queue_empty", exp_b.size(), 0);
                check("b_done_busy_low", busy_b, 0);
            end
        end
    end

    task automatic load_frame_a(input bit seq);
        exp_t e;
        for (int i = 0; i < NA; i++) px_a[i] = seq ? DW'(i + 1) : DW'($urandom_range(1, 255));
        for (int i = 0; i < NA + PA * WA; i++) begin
            e.d   = (i < NA) ? px_a[i] : '0;
            e.r   = i / WA;
            e.c   = i % WA;
            e.pad = (i >= NA);
            exp_a.push_back(e);
        end
        xfer_a = 0; acc_a = 0; run_a = 0; max_run_a = 0; low_a = 0; max_low_a = 0;
    endtask

    // gap < 0 means a random gap of 0..3 idle cycles per pixel.
    task automatic send_frame_a(input int gap, input bit seq, input bit mid_start,
                                input bit start_on_done);
        bit acc;
        int dc;
        load_frame_a(seq);
        dc = done_cnt_a;
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int i = 0; i < NA; i++) begin
            ifa.s_valid = 1'b1;
            ifa.s_data  = px_a[i];
            if (mid_start && i == 5) start_a = 1'b1;
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = ifa.s_ready;
                @(posedge clk); #1;
            end
            ifa.s_valid = 1'b0;
            start_a     = 1'b0;
            if (!acc) begin
                check("a_accept_timeout", 0, 1);
                return;
            end
            repeat ((gap < 0) ? $urandom_range(0, 3) : gap) begin
                @(posedge clk); #1;
            end
        end
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done_a) break;
        end
        check("a_done_seen", done_a, 1);
        if (start_on_done) start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        check("a_idle_after_done", busy_a, 0);
        repeat (3) @(posedge clk);
        #1 check("a_single_done_pulse", done_cnt_a - dc, 1);
    endtask

    initial begin
        bit acc;
        exp_t e;
        start_a = 1'b0; start_b = 1'b0;
        ifa.s_valid = 1'b0; ifa.s_data = '0;
        ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.m_ready = 1'b1;
        xfer_a = 0; acc_a = 0; run_a = 0; max_run_a = 0; low_a = 0; max_low_a = 0;
        done_cnt_a = 0; first_acc_a = 0; first_xfer_a = 0; last_xfer_a = 0;
        xfer_b = 0; last_xfer_b = 0;

        #2;
        check("a_reset_outputs", {ifa.s_ready, ifa.lb_valid, ifa.lb_data, ifa.col, ifa.row,
                                  ifa.pad_active, busy_a, done_a}, 0);
        check("b_reset_outputs", {ifb.s_ready, ifb.lb_valid, ifb.lb_data, ifb.col, ifb.row,
                                  ifb.pad_active, busy_b, done_b}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Upstream valid before start must not be consumed.
        ifa.s_valid = 1'b1; ifa.s_data = 8'haa;
        repeat (5) @(posedge clk);
        #1 ifa.s_valid = 1'b0;
        check("a_no_accept_before_start", acc_a, 0);
        check("a_not_busy_before_start", busy_a, 0);

        // Continuous frame with data 1..12; a start on the done cycle must be ignored.
        mode_a = 0;
        send_frame_a(0, 1'b1, 1'b0, 1'b1);
        check("a_continuous_run", max_run_a, NA + PA * WA);
        check("a_s_ready_never_low", max_low_a, 0);
        check("a_latency", first_xfer_a - first_acc_a, 1);
        check("a_xfer_count", xfer_a, NA + PA * WA);

        // Downstream backpressure 1,0,0,1.
        mode_a = 1;
        send_frame_a(0, 1'b0, 1'b0, 1'b0);
        check("a_stall_s_ready_low_bound", max_low_a <= 3, 1);
        check("a_stall_xfer_count", xfer_a, NA + PA * WA);

        // Upstream gaps: one valid in three; pads follow the last pixel back to back.
        mode_a = 0;
        send_frame_a(2, 1'b0, 1'b0, 1'b0);
        check("a_gap_tail_run", max_run_a, 1 + PA * WA);

        // Start pulsed mid-frame is ignored.
        send_frame_a(0, 1'b0, 1'b1, 1'b0);

        // Reset after five outputs, then a fresh frame.
        load_frame_a(1'b1);
        @(posedge clk); #1 start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        for (int i = 0; i < NA && xfer_a < 5; i++) begin
            ifa.s_valid = 1'b1;
            ifa.s_data  = px_a[i];
            @(posedge clk); #1;
        end
        check("a_outputs_before_reset", xfer_a, 5);
        #2 rst_n = 1'b0;
        #1;
        check("a_midframe_reset_outputs", {ifa.s_ready, ifa.lb_valid, ifa.lb_data, ifa.col,
                                           ifa.row, ifa.pad_active, busy_a, done_a}, 0);
        ifa.s_valid = 1'b0;
        exp_a.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        acc_a = 0;
        ifa.s_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1 ifa.s_valid = 1'b0;
        check("a_partial_frame_not_resumed", busy_a, 0);
        check("a_no_accept_after_reset", acc_a, 0);
        send_frame_a(0, 1'b0, 1'b0, 1'b0);
        check("a_fresh_frame_count", xfer_a, NA + PA * WA);

        // Randomized stalls and gaps.
        mode_a = 2;
        for (int f = 0; f < 3; f++) begin
            send_frame_a(-1, 1'b0, 1'b0, 1'b0);
            check("a_random_xfer_count", xfer_a, NA + PA * WA);
        end
        mode_a = 0;

        // No padding instance.
        for (int i = 0; i < WB * HB; i++) begin
            px_b[i] = DW'($urandom_range(0, 255));
            e.d = px_b[i]; e.r = i / WB; e.c = i % WB; e.pad = 1'b0;
            exp_b.push_back(e);
        end
        xfer_b = 0;
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        for (int i = 0; i < WB * HB; i++) begin
            ifb.s_valid = 1'b1;
            ifb.s_data  = px_b[i];
            acc = 1'b0;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                acc = ifb.s_ready;
                @(posedge clk); #1;
            end
            ifb.s_valid = 1'b0;
            if (!acc) begin
                check("b_accept_timeout", 0, 1);
                break;
            end
        end
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (done_b) break;
        end
        check("b_done_seen", done_b, 1);
        check("b_xfer_count", xfer_b, WB * HB);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/gauss_raster_feeder.md
# gauss_raster_feeder

Raster pixel source for the 5x5 Gaussian line buffer: it drives that buffer's `valid_in`/`din` write interface. It accepts one frame of `IMG_WIDTH` x `IMG_HEIGHT` pixels from an upstream valid/ready stream and forwards them in raster order. After the last real pixel it appends `PAD_ROWS` rows of zero pixels, so the window pipeline flushes the bottom image rows. Downstream stalls (`m_ready` low) suppress `lb_valid`; a skid stage keeps `s_ready` registered.

## Interface
- `DATA_WIDTH`, default 8: pixel width.
- `IMG_WIDTH`, default 128: pixels per row; must be ≥2.
- `IMG_HEIGHT`, default 128: real rows per frame; must be ≥1.
- `PAD_ROWS`, default 2: zero rows appended after the frame; range 0..4.
- `clk` input, 1 bit: clock.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `start` input, 1 bit: one-cycle pulse that begins a frame; ignored while `busy`.
- `s_valid` input, 1 bit: upstream pixel valid.
- `s_ready` output, 1 bit: registered; an upstream transfer occurs when `s_valid && s_ready`.
- `s_data` input, `DATA_WIDTH` bits: upstream pixel.
- `m_ready` input, 1 bit: downstream may accept a pixel this cycle.
- `lb_valid` output, 1 bit: connects to the line buffer `valid_in`; asserted means the pixel is transferred this cycle.
- `lb_data` output, `DATA_WIDTH` bits: connects to the line buffer `din`.
- `col` output, `$clog2(IMG_WIDTH)` bits: column of the pixel on `lb_data`.
- `row` output, `$clog2(IMG_HEIGHT+PAD_ROWS)` bits: row of the pixel on `lb_data`.
- `pad_active` output, 1 bit: the pixel on `lb_data` is a pad pixel.
- `busy` output, 1 bit: a frame is in progress.
- `done` output, 1 bit: one-cycle pulse at frame completion.

## Operation
- **Reset values:** `s_ready`=0, `lb_valid`=0, `lb_data`=0, `col`=0, `row`=0, `pad_active`=0, `busy`=0, `done`=0. State is IDLE; the output register (OR) and skid entry (SK) are empty; all counters are 0.
- **IDLE:**
  - `s_ready`=0.
  - `start` clears the counters and moves to STREAM.
  - `s_valid` is ignored and no input is consumed.
- **STREAM:**
  - `s_ready` is registered and equals `!SK_full && in_cnt < W*H`.
  - An accepted pixel enters OR if OR is empty or draining this cycle; otherwise it enters SK.
  - When OR drains and SK is full, SK moves to OR.
  - `in_cnt` increments on each accept. When it reaches W*H, `s_ready` drops on the next edge.
- **FLUSH:**
  - Entered once `in_cnt` = W*H and SK is empty.
  - Zero pixels with the pad flag set are loaded into OR whenever OR is empty or draining, until `PAD_ROWS*W` pads have been generated.
  - If `PAD_ROWS`=0, FLUSH is skipped and the block goes straight to DRAIN.
- **DRAIN:**
  - The block waits for the final OR entry to transfer.
  - It then pulses `done`, deasserts `busy`, and returns to IDLE.
- **Output path:**
  - `lb_valid` = `OR_full && m_ready`, combinational in `m_ready`. The line buffer has no ready signal, so the cycle in which `lb_valid` is high is the transfer.
  - `lb_data`, `col`, `row` and `pad_active` come from OR and are held while OR is full and not transferring.
- **Position counters:**
  - `col`/`row` advance on each output transfer.
  - `col` wraps from W-1 to 0 and increments `row`.
  - After the last pad pixel, `row` wraps to 0.
  - `row` ≥ `IMG_HEIGHT` exactly when `pad_active`=1.
- `busy` is 1 from the cycle after `start` until the `done` cycle, where it is 0.
- `start` while `busy` is ignored with no effect. `start` in the same cycle as `done` is also ignored.
- Asserting `rst_n` mid-frame returns all outputs to their reset values immediately. A partial frame is discarded and never resumed.

## Timing
- **Start:** `start` sampled at edge 0 gives `busy`=1 and `s_ready`=1 from edge 0.
- **Accept to output:** a pixel accepted at edge N appears with `lb_valid`=1 (given `m_ready`) in the cycle after edge N. Latency is 1 cycle.
- **Sustained throughput:** with `s_valid`=`m_ready`=1 continuously, throughput is 1 pixel per cycle and `lb_valid` never drops between the last real pixel and the first pad pixel.
- **Stall:** if `m_ready` drops for K cycles, at most 2 more pixels are accepted before `s_ready` falls. `s_ready` returns 1 cycle after SK drains. No pixel is lost or duplicated.
- **Done:** `done` is asserted in the cycle after the final transfer's edge. `busy`=0 in that same cycle.

## Test plan
- **Continuous frame:** W=4, H=3, PAD=2, `s_data`=1..12, `s_valid`=`m_ready`=1 → `lb_valid` high for 20 consecutive cycles. `lb_data` is 1..12 followed by eight 0s. `pad_active` is high for the last 8. `row`/`col` sequence is (0,0)…(4,3). `done` is one pulse the cycle after.
- **Downstream backpressure:** same frame, `m_ready` toggling 1,0,0,1 repeating → output sequence identical to the continuous case. `s_ready` low for no more than the stall length plus 1. No `lb_valid` while `m_ready`=0.
- **Upstream gaps:** `s_valid` high one cycle in three → `lb_valid` pulses spaced 3 cycles apart, data in order. Pads stream back-to-back once `in_cnt`=12.
- **Start/idle handling:** `s_valid`=1 before `start` → `s_ready`=0 and nothing accepted. `start` pulsed mid-frame → ignored, frame output unchanged.
- **Reset mid-frame:** `rst_n` low after 5 outputs → all outputs 0 immediately. A new `start` then produces a full fresh frame beginning at (0,0).
- **No padding:** PAD=0, W=4, H=2 → 8 transfers with no `pad_active`. `done` the cycle after the 8th transfer.
